// File: rtl/wb_pkg.sv
// Shared writeback types: register widths and the queued-write entry.
// Also consumed by decode for pending-flag logic.
package wb_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  typedef struct packed {
    logic                  live;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular store for long-latency writebacks with per-entry kill.
// Popped slots drop their live bit so live implies occupied.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic [DEPTH-1:0]      kill_i,
  output logic [DEPTH-1:0]      live_o,
  output logic [ADDR_WIDTH-1:0] rd_o [DEPTH],
  output wb_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    for (int i = 0; i < DEPTH; i++) begin
      live_o[i] = mem_q[i].live;
      rd_o[i]   = mem_q[i].rd;
    end
    head_o  = mem_q[head_q];
    count_o = count_q;
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_i[i]) mem_q[i].live <= 1'b0;
      if (pop_i) begin
        mem_q[head_q].live <= 1'b0;
        head_q             <= head_q + PW'(1);
      end
      if (push_i) begin
        mem_q[tail_q] <= push_entry_i;
        tail_q        <= tail_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Merges pipeline and long-latency writebacks onto one RF write port.
// Pipe writes win; queued writes drain in idle slots.
module writeback_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pipe_write,
  input  logic [ADDR_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [ADDR_WIDTH-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] rs1_address,
  input  logic [ADDR_WIDTH-1:0] rs2_address,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic [CW-1:0]         queue_count
);

  logic                  pipe_hit, push, pop;
  logic                  full, empty;
  wb_entry_t             head, push_entry;
  logic [DEPTH-1:0]      live, kill;
  logic [ADDR_WIDTH-1:0] rds [DEPTH];
  logic [CW-1:0]         count;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (kill),
    .live_o       (live),
    .rd_o         (rds),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    pipe_hit = !reset && pipe_write && (pipe_rd != '0);
    lu_ready = !reset && !full;
    push     = lu_valid && lu_ready && (lu_rd != '0);
    pop      = !reset && !pipe_hit && !empty;

    // A same-cycle pipe write to the same rd is program-later.
    push_entry.live = !(pipe_hit && (lu_rd == pipe_rd));
    push_entry.rd   = lu_rd;
    push_entry.data = lu_data;

    reg_write  = 1'b0;
    rd_address = '0;
    write_data = '0;
    if (pipe_hit) begin
      reg_write  = 1'b1;
      rd_address = pipe_rd;
      write_data = pipe_data;
    end else if (pop && head.live) begin
      reg_write  = 1'b1;
      rd_address = head.rd;
      write_data = head.data;
    end

    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = pipe_hit && live[i] && (rds[i] == pipe_rd);
      if (live[i] && (rds[i] == rs1_address)) rs1_pending = 1'b1;
      if (live[i] && (rds[i] == rs2_address)) rs2_pending = 1'b1;
    end
    rs1_pending = rs1_pending && !reset && (rs1_address != '0);
    rs2_pending = rs2_pending && !reset && (rs2_address != '0);

    queue_count = reset ? '0 : count;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench: queue-level reference model predicts RF writes,
// a negedge monitor pops and compares what the port presents.
module tb_writeback_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_write = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [63:0] pipe_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = '0;
  logic [63:0] lu_data = '0;
  logic        reg_write;
  logic [4:0]  rd_address;
  logic [63:0] write_data;
  logic [4:0]  rs1_address = '0;
  logic [4:0]  rs2_address = '0;
  logic        rs1_pending, rs2_pending;
  logic [2:0]  queue_count;

  always #5 clock = ~clock;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .pipe_write  (pipe_write),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .reg_write   (reg_write),
    .rd_address  (rd_address),
    .write_data  (write_data),
    .rs1_address (rs1_address),
    .rs2_address (rs2_address),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .queue_count (queue_count)
  );

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [63:0] data;
  } m_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } w_t;

  m_t mq[$];
  w_t sb[$];
  w_t mw;
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check state-level outputs, advance the model.
  task automatic cyc(input bit rst, input bit pw, input logic [4:0] prd,
                     input logic [63:0] pdata, input bit lv,
                     input logic [4:0] lrd, input logic [63:0] ldata,
                     input logic [4:0] r1, input logic [4:0] r2);
    bit hit, rdy, p1, p2;
    int n;
    m_t e;
    @(posedge clock);
    #1;
    reset = rst; pipe_write = pw; pipe_rd = prd; pipe_data = pdata;
    lu_valid = lv; lu_rd = lrd; lu_data = ldata;
    rs1_address = r1; rs2_address = r2;
    #1;
    n   = mq.size();
    rdy = !rst && (n < DEPTH);
    p1  = 1'b0;
    p2  = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].live && mq[i].rd == r1) p1 = 1'b1;
      if (mq[i].live && mq[i].rd == r2) p2 = 1'b1;
    end
    p1 = p1 && !rst && (r1 != 0);
    p2 = p2 && !rst && (r2 != 0);
    chk("lu_ready", 64'(lu_ready), 64'(rdy));
    chk("queue_count", 64'(queue_count), rst ? 64'd0 : 64'(n));
    chk("rs1_pending", 64'(rs1_pending), 64'(p1));
    chk("rs2_pending", 64'(rs2_pending), 64'(p2));
    if (rst) begin
      chk("rd_address in reset", 64'(rd_address), 64'd0);
      chk("write_data in reset", write_data, 64'd0);
      mq.delete();
      return;
    end
    hit = pw && (prd != 0);
    if (hit) begin
      sb.push_back('{rd: prd, data: pdata});
      foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
    end else if (n > 0) begin
      e = mq.pop_front();
      if (e.live) sb.push_back('{rd: e.rd, data: e.data});
    end
    if (lv && rdy && lrd != 0)
      mq.push_back('{live: !(hit && lrd == prd), rd: lrd, data: ldata});
  endtask

  initial begin
    forever begin
      @(negedge clock);
      chk("reg_write", 64'(reg_write), 64'(sb.size() > 0));
      if (reg_write && sb.size() > 0) begin
        mw = sb.pop_front();
        chk("rd_address", 64'(rd_address), 64'(mw.rd));
        chk("write_data", write_data, mw.data);
      end
      sb.delete();
    end
  end

  logic [4:0] bp [6];
  int pprob;

  initial begin
    bp = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd6};
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 64'h5, 1, 4, 64'h6, 3, 4);
    // pass-through
    cyc(0, 0, 0, 0, 1, 5, 64'hAA, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
    // backpressure behind a busy pipeline
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 7, 64'(i), 1, bp[i], 64'h100 + 64'(i), bp[i], 7);
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 0, i < 2, 6, 64'h106, 1, 6);
    // WAW kill
    cyc(0, 0, 0, 0, 1, 9, 64'h11, 9, 0);
    cyc(0, 1, 9, 64'h22, 0, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 9, 0);
    // x0 handling
    cyc(0, 1, 7, 1, 1, 0, 64'h33, 0, 0);
    cyc(0, 1, 7, 2, 1, 3, 64'h33, 3, 0);
    cyc(0, 1, 0, 64'h44, 0, 0, 0, 3, 0);
    // pending flags
    cyc(0, 1, 7, 3, 1, 12, 64'hC, 12, 0);
    cyc(0, 1, 7, 4, 1, 13, 64'hD, 12, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 12, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 12, 13);
    cyc(0, 0, 0, 0, 0, 0, 0, 12, 13);
    // reset mid-drain
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 7, 5, 1, 5'(20 + i), 64'(i), 20, 21);
    cyc(1, 0, 0, 0, 0, 0, 0, 20, 21);
    cyc(0, 0, 0, 0, 0, 0, 0, 20, 21);
    cyc(0, 0, 0, 0, 0, 0, 0, 20, 21);
    // randomized traffic with phase-varying pipeline load
    pprob = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) pprob = $urandom_range(0, 95);
      cyc($urandom_range(0, 249) == 0,
          $urandom_range(0, 99) < pprob,
          5'($urandom_range(0, 12)),
          {$urandom, $urandom},
          $urandom_range(0, 99) < 60,
          5'($urandom_range(0, 12)),
          {$urandom, $urandom},
          5'($urandom_range(0, 12)),
          5'($urandom_range(0, 12)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #6;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register-file write requests from the long-latency execution unit (loads and multi-cycle multiply/divide) and merges them with the main pipeline's writeback onto the single register-file write port. It sits directly in front of `register_file`, driving its `reg_write`, `rd_address` and `write_data` inputs. It also exposes per-source-register pending flags, which the decode stage uses for stall decisions.

## Interface
- `DATA_WIDTH`, 64, register data width
- `ADDR_WIDTH`, 5, register address width (32 registers, x0 hardwired zero)
- `DEPTH`, 4, queue entries; power of two, at least 2

- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `pipe_write`  in  1  pipeline writeback request this cycle; always accepted, never stalled
- `pipe_rd`  in  ADDR_WIDTH  pipeline destination register
- `pipe_data`  in  DATA_WIDTH  pipeline result
- `lu_valid`  in  1  long-latency result offered
- `lu_ready`  out  1  queue can accept; a transfer occurs when `lu_valid && lu_ready`
- `lu_rd`  in  ADDR_WIDTH  long-latency destination register
- `lu_data`  in  DATA_WIDTH  long-latency result
- `reg_write`  out  1  to register file write enable
- `rd_address`  out  ADDR_WIDTH  to register file write address
- `write_data`  out  DATA_WIDTH  to register file write data
- `rs1_address`, `rs2_address`  in  ADDR_WIDTH  decode-stage source registers to probe
- `rs1_pending`, `rs2_pending`  out  1  a live queued write targets that source register
- `queue_count`  out  $clog2(DEPTH+1)  occupied entries, including killed entries

## Operation
- **Entry contents:** `live`, `rd`, `data`. The queue is a circular FIFO with head and tail pointers and a count.
- **Enqueue:** on an `lu_valid && lu_ready` transfer, an entry is written at the tail.
  - If `lu_rd == 0`, the transfer is accepted and no entry is written.
- **Port arbitration (per cycle, combinational):**
  - If `pipe_write && pipe_rd != 0`: drive the port from the pipe inputs. The queue does not pop.
  - Otherwise, if the queue is non-empty: pop the head. If the head is live, drive `reg_write=1` with its `rd`/`data`. If the head is killed, pop silently with `reg_write=0`.
  - Otherwise: `reg_write=0`.
- **x0 writes:** `pipe_write` with `pipe_rd == 0` never drives `reg_write` and does not block the queue from popping.
- **WAW kill:** when `pipe_write && pipe_rd != 0`, every live entry with `rd == pipe_rd` is cleared to `live=0` at the clock edge.
  - This includes an entry being enqueued in the same cycle; the pipeline write is treated as program-later.
  - Killed entries still occupy slots until popped.
- **Pending flags (combinational):** `rsN_pending = (rsN_address != 0)` AND any live occupied entry has `rd == rsN_address`.
  - An entry being popped in the current cycle still counts as pending.
  - An entry being enqueued in the current cycle does not count.
- **`lu_ready`:** equals `count < DEPTH`, computed from the registered count. It is not raised by a same-cycle pop, so a full queue accepts nothing until the cycle after a pop. `lu_ready` is 0 while `reset` is high.
- **Count update:** `count_next = count + push - pop`; a simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.

## Timing
- **Reset values:** count 0, head and tail 0, all entries cleared to `live=0`, `queue_count=0`, `lu_ready=0`, `reg_write=0`, `rd_address=0`, `write_data=0`, pending flags 0.
- **Reset mid-operation:** all queued entries are discarded with no writes issued. The first write possible after reset is a pipe write in the cycle after `reset` falls.
- **Pipe path latency:** 0 cycles. The port is driven in the same cycle, and the register file captures it at the next edge.
- **Queue path latency:** an entry accepted at edge N can be driven on the port in the cycle after edge N, at the earliest. It waits while the pipeline holds the port.
- **Starvation:** the queue drains only in cycles with no non-zero-rd pipe write. The pipeline guarantees idle slots; this block adds no forced drain.

## Structure
- **Shared package `wb_pkg`:** `DATA_WIDTH`, `ADDR_WIDTH`, and the `wb_entry_t` struct (`live`, `rd`, `data`). The same package is reused by decode for pending-flag consumers.
- **Sub-module `wb_fifo`:** circular storage, pointers, count, full/empty, plus a kill-by-rd match vector input. The top level holds arbitration and the pending compare logic.

## Test plan
- **Basic pass-through:** reset, then lu push rd=5, data=0xAA; no pipe writes → `reg_write=1`, `rd_address=5`, `write_data=0xAA` one cycle after acceptance; `queue_count` returns to 0.
- **Backpressure:** hold `pipe_write=1` (rd=7) for 6 cycles while pushing rd=1..4 then rd=6.
  - `lu_ready` drops after 4 accepts; `queue_count=4`.
  - When pipe writes stop, entries drain in order 1, 2, 3, 4 on consecutive cycles.
  - rd=6 is accepted only the cycle after the first pop.
- **WAW kill:** queue rd=9 data=0x11, then pipe write rd=9 data=0x22 in the same cycle as the queue would pop.
  - The pipe write wins and the entry is killed.
  - The following cycle pops with `reg_write=0`; register 9 ends at 0x22.
- **x0 handling:** lu push rd=0 → accepted, `queue_count` unchanged. Pipe write rd=0 with queue holding rd=3 → rd=3 is written that cycle.
- **Pending flags:** queue rd=12 and rd=13; probe rs1=12, rs2=0 → `rs1_pending=1`, `rs2_pending=0`. After rd=12 pops, `rs1_pending=0` the next cycle.
- **Reset mid-drain:** queue 3 entries, assert `reset` for 1 cycle → no further `reg_write`, `queue_count=0`, `lu_ready=0` during reset and 1 after.
